branch_fwd_ctrl: RTL

- Hazard and forwarding controller for the branch comparator in the X stage.
- Tracks destination registers of the instructions in the X, M and W slots.
- Drives the 2-bit operand-select codes consumed by the comparator: 00 = register file, 10 = X/M forward, 11 = M/W forward.
- Detects load-use hazards on branch operands, stalls D for one cycle and injects a bubble into M. Applies taken-branch flushes of the D-stage instruction.

---
 rtl/branch_fwd_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/branch_fwd_ctrl.sv
// Hazard and forwarding controller for the X-stage branch comparator.
// Tracks producers in the X, M and W slots, selects forwarding paths and stalls D on load-use.
module branch_fwd_ctrl #(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              d_valid,
  input  logic [REG_AW-1:0] d_rs1,
  input  logic [REG_AW-1:0] d_rs2,
  input  logic              d_use_rs1,
  input  logic              d_use_rs2,
  input  logic [REG_AW-1:0] d_rd,
  input  logic              d_reg_write,
  input  logic              d_is_load,
  input  logic              hold,
  input  logic              flush,
  output logic              d_ready,
  output logic              load_use,
  output logic              x_valid,
  output logic [1:0]        b_operand1_sel,
  output logic [1:0]        b_operand2_sel
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              use1;
    logic              use2;
    logic [REG_AW-1:0] rd;
    logic              wr;
    logic              load;
  } x_slot_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              wr;
    logic              load;
  } mw_slot_t;

  typedef enum logic [1:0] {
    SEL_RF = 2'b00,
    SEL_XM = 2'b10,
    SEL_MW = 2'b11
  } sel_t;

  x_slot_t  x_q;
  mw_slot_t m_q;
  mw_slot_t w_q;

  x_slot_t  d_slot;
  mw_slot_t x_as_mw;

  logic m1_hit, m2_hit, w1_hit, w2_hit;
  logic lu1, lu2;
  sel_t sel1, sel2;

  // A producer matches only if it actually writes a non-zero register.
  function automatic logic slot_hit(input logic              x_ok,
                                    input logic              use_n,
                                    input logic [REG_AW-1:0] rs,
                                    input mw_slot_t          p);
    return x_ok & use_n & p.valid & p.wr & (p.rd != '0) & (p.rd == rs);
  endfunction

  function automatic sel_t pick_sel(input logic m_hit, input logic m_load, input logic w_hit);
    if (m_hit && !m_load) return SEL_XM;
    else if (m_hit)       return SEL_RF;
    else if (w_hit)       return SEL_MW;
    else                  return SEL_RF;
  endfunction

  assign m1_hit = slot_hit(x_q.valid, x_q.use1, x_q.rs1, m_q);
  assign m2_hit = slot_hit(x_q.valid, x_q.use2, x_q.rs2, m_q);
  assign w1_hit = slot_hit(x_q.valid, x_q.use1, x_q.rs1, w_q);
  assign w2_hit = slot_hit(x_q.valid, x_q.use2, x_q.rs2, w_q);

  assign lu1 = m1_hit & m_q.load;
  assign lu2 = m2_hit & m_q.load;

  // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    sel1 = SEL_RF;
    sel2 = SEL_RF;
    sel1 = pick_sel(m1_hit, m_q.load, w1_hit);
    sel2 = pick_sel(m2_hit, m_q.load, w2_hit);
  end

  assign load_use       = lu1 | lu2;
  assign d_ready        = ~hold & ~load_use;
  assign x_valid        = x_q.valid;
  assign b_operand1_sel = sel1;
  assign b_operand2_sel = sel2;

  // Flushed or invalid D instructions enter X as an all-zero bubble.
  always_comb begin
    d_slot = '0;
    if (d_valid && !flush) begin
      d_slot.valid = 1'b1;
      d_slot.rs1   = d_rs1;
      d_slot.rs2   = d_rs2;
      d_slot.use1  = d_use_rs1;
      d_slot.use2  = d_use_rs2;
      d_slot.rd    = d_rd;
      d_slot.wr    = d_reg_write;
      d_slot.load  = d_is_load;
    end
  end

  assign x_as_mw = '{valid: x_q.valid, rd: x_q.rd, wr: x_q.wr, load: x_q.load};

  // NOTE: slot registers use non-blocking assignments so W <= M and M <= X all see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else if (hold) begin
      x_q <= x_q;
      m_q <= m_q;
      w_q <= w_q;
    end else if (load_use) begin
      // The branch waits in X; the load advances and a bubble fills M.
      m_q <= '0;
      w_q <= m_q;
    end else begin
      x_q <= d_slot;
      m_q <= x_as_mw;
      w_q <= m_q;
    end
  end

endmodule
